// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - integer register file with busy scoreboard, write bypass and multi-port reads
//
// Ports:
//   clock, reset_n       sole clock (rising edge), asynchronous active-low reset
//   rd_addr / rd_data    packed read ports, port k at [k*ADDRW +: ADDRW] / [k*DATAW +: DATAW]
//   rd_busy              per-port pending-operand flag
//   wr_en/wr_addr/wr_data  writeback
//   claim_en/claim_addr  issue-side destination claim, claim_ready = accepted this cycle
//   flush                clears the whole scoreboard
//   busy_vec             scoreboard state, bit i = register i busy
//   stray_write          registered pulse: previous cycle wrote a register that was not busy
module scoreboard_register_file #(
    parameter int               DATAW        = 32,
    parameter int               NUM_REGS     = 32,
    parameter int               ADDRW        = $clog2(NUM_REGS),
    parameter int               NUM_RD_PORTS = 2,
    parameter bit               BYPASS       = 1'b1,
    parameter int               SP_INDEX     = 2,
    parameter logic [DATAW-1:0] SP_INIT      = 32'h01001000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_RD_PORTS*ADDRW-1:0]   rd_addr,
    output logic [NUM_RD_PORTS*DATAW-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]         rd_busy,
    input  logic                            wr_en,
    input  logic [ADDRW-1:0]                wr_addr,
    input  logic [DATAW-1:0]                wr_data,
    input  logic                            claim_en,
    input  logic [ADDRW-1:0]                claim_addr,
    output logic                            claim_ready,
    input  logic                            flush,
    output logic [NUM_REGS-1:0]             busy_vec,
    output logic                            stray_write
);

    logic [DATAW-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    logic wr_hit;
    logic claim_take;

    // Writes to x0 are dropped entirely: no storage update, no busy change, no stray flag.
    assign wr_hit = wr_en && (wr_addr != '0);

    // A claim on a busy register is still accepted when that register is being
    // written back in the same cycle, so issue does not lose a cycle.
    assign claim_ready = !flush && ((claim_addr == '0) || !busy_q[claim_addr] ||
                                    (wr_en && (wr_addr == claim_addr)));
    assign claim_take  = claim_en && claim_ready && (claim_addr != '0);

    assign busy_vec = busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
            busy_q      <= '0;
            stray_write <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[wr_addr] <= wr_data;
            end
            stray_write <= wr_hit && !busy_q[wr_addr];
            if (flush) begin
                busy_q <= '0;
            end else begin
                if (wr_hit) begin
                    busy_q[wr_addr] <= 1'b0;
                end
                // Issued after the writeback clear so a same-register claim wins.
                if (claim_take) begin
                    busy_q[claim_addr] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDRW-1:0] addr_k;
        logic             zero_k;
        logic             hit_k;

        assign addr_k = rd_addr[k*ADDRW +: ADDRW];
        assign zero_k = (addr_k == '0);
        assign hit_k  = BYPASS && wr_en && (wr_addr == addr_k);

        assign rd_data[k*DATAW +: DATAW] = zero_k ? '0 :
                                           hit_k  ? wr_data : regs[addr_k];
        assign rd_busy[k] = !zero_k && !hit_k && busy_q[addr_k];
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb/tb_scoreboard_register_file.sv - directed bench for scoreboard_register_file (bypass and non-bypass instances)
module tb_scoreboard_register_file;

    localparam int DATAW = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam logic [31:0] SP_INIT = 32'h01001000;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [4*AW-1:0] rd_addr = '0;
    logic [2*AW-1:0] rd_addr_b;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic            claim_en = 1'b0;
    logic [AW-1:0]   claim_addr = '0;
    logic            flush = 1'b0;

    logic [4*DATAW-1:0] rd_data_a;
    logic [3:0]         rd_busy_a;
    logic               claim_ready_a;
    logic [NREGS-1:0]   busy_vec_a;
    logic               stray_a;

    logic [2*DATAW-1:0] rd_data_b;
    logic [1:0]         rd_busy_b;
    logic               claim_ready_b;
    logic [NREGS-1:0]   busy_vec_b;
    logic               stray_b;

    int checks = 0;
    int errors = 0;

    assign rd_addr_b = rd_addr[2*AW-1:0];

    always #5 clock = ~clock;

    scoreboard_register_file #(.NUM_RD_PORTS(4), .BYPASS(1'b1)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ready(claim_ready_a),
        .flush(flush), .busy_vec(busy_vec_a), .stray_write(stray_a)
    );

    scoreboard_register_file #(.NUM_RD_PORTS(2), .BYPASS(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ready(claim_ready_b),
        .flush(flush), .busy_vec(busy_vec_b), .stray_write(stray_b)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        rd_addr = {4{a}};
    endtask

    task automatic idle();
        wr_en = 1'b0;
        claim_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle();
        reset_n = 1'b0;
        cyc();
        checks++;
        if (busy_vec_a !== 32'h0 || stray_a !== 1'b0 || claim_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: busy_vec=%h stray=%b claim_ready=%b required 0 0 1", busy_vec_a, stray_a, claim_ready_a);
        end
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a));
            #1;
            exp = (a == 2) ? SP_INIT : 32'h0;
            checks++;
            if (rd_data_a[31:0] !== exp || rd_data_b[31:0] !== exp || rd_busy_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg x%0d: a=%h b=%h busy=%b required %h busy 0", a, rd_data_a[31:0], rd_data_b[31:0], rd_busy_a[0], exp);
            end
        end
        reset_n = 1'b1;

        // Build state mid-run, then assert reset between edges.
        claim_en = 1'b1; claim_addr = 5;
        cyc();
        claim_en = 1'b0;
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
        cyc();
        wr_en = 1'b0;
        set_rd(7);
        #1;
        checks++;
        if (busy_vec_a !== 32'h20 || stray_a !== 1'b1 || rd_data_b[31:0] !== 32'h55) begin
            errors++;
            $display("FAIL pre_reset: busy_vec=%h stray=%b x7=%h required 00000020 1 00000055", busy_vec_a, stray_a, rd_data_b[31:0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0 || stray_a !== 1'b0 || rd_data_b[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy_vec=%h stray=%b x7=%h required 0 0 0", busy_vec_a, stray_a, rd_data_b[31:0]);
        end
        rd_addr = {AW'(5), AW'(2), AW'(5), AW'(2)};
        #1;
        checks++;
        if (rd_data_a[31:0] !== SP_INIT || rd_busy_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_sp: x2=%h x5_busy=%b required %h 0", rd_data_a[31:0], rd_busy_a[1], SP_INIT);
        end
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_bypass();
        claim_en = 1'b1; claim_addr = 7;
        cyc();
        claim_en = 1'b0;
        set_rd(7);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_on: data=%h busy=%b required deadbeef 0", rd_data_a[31:0], rd_busy_a[0]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'h0 || rd_busy_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_off: data=%h busy=%b required 00000000 1", rd_data_b[31:0], rd_busy_b[0]);
        end
        cyc();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_b[31:0] !== 32'hDEADBEEF || rd_busy_b[0] !== 1'b0 || stray_a !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after_edge: data=%h busy=%b stray=%b required deadbeef 0 0", rd_data_b[31:0], rd_busy_b[0], stray_a);
        end
    endtask

    task automatic test_scoreboard();
        set_rd(9);
        claim_en = 1'b1; claim_addr = 9;
        #1;
        checks++;
        if (claim_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL claim_first: claim_ready=%b required 1", claim_ready_a);
        end
        cyc();
        #1;
        checks++;
        if (rd_busy_a !== 4'hF || rd_busy_b !== 2'b11 || claim_ready_a !== 1'b0 || busy_vec_a !== 32'h200) begin
            errors++;
            $display("FAIL claim_busy: rd_busy=%h/%b claim_ready=%b busy_vec=%h required f/11 0 00000200", rd_busy_a, rd_busy_b, claim_ready_a, busy_vec_a);
        end
        cyc();
        claim_en = 1'b0;
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h12;
        #1;
        checks++;
        if (busy_vec_a !== 32'h200 || rd_data_a[31:0] !== 32'h12) begin
            errors++;
            $display("FAIL claim_held: busy_vec=%h bypass_data=%h required 00000200 00000012", busy_vec_a, rd_data_a[31:0]);
        end
        cyc();
        wr_en = 1'b0;
        #1;
        checks++;
        if (busy_vec_a !== 32'h0 || rd_data_b[31:0] !== 32'h12 || rd_busy_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL release: busy_vec=%h data=%h busy=%b required 0 00000012 0", busy_vec_a, rd_data_b[31:0], rd_busy_b[0]);
        end
    endtask

    task automatic test_simultaneous();
        claim_en = 1'b1; claim_addr = 4;
        cyc();
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h44;
        set_rd(4);
        #1;
        checks++;
        if (claim_ready_a !== 1'b1 || claim_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL claim_with_write: claim_ready=%b/%b required 1", claim_ready_a, claim_ready_b);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (busy_vec_a !== 32'h10 || rd_data_b[31:0] !== 32'h44 || rd_busy_b[0] !== 1'b1 || stray_a !== 1'b0) begin
            errors++;
            $display("FAIL claim_wins: busy_vec=%h data=%h busy=%b stray=%b required 00000010 00000044 1 0", busy_vec_a, rd_data_b[31:0], rd_busy_b[0], stray_a);
        end

        flush = 1'b1;
        claim_en = 1'b1; claim_addr = 6;
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33;
        rd_addr = {AW'(0), AW'(0), AW'(6), AW'(3)};
        #1;
        checks++;
        if (claim_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL flush_claim_ready: claim_ready=%b required 0", claim_ready_a);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0 || rd_data_b[31:0] !== 32'h33 || rd_busy_b[1] !== 1'b0 || stray_a !== 1'b1) begin
            errors++;
            $display("FAIL flush: busy_vec=%h x3=%h x6_busy=%b stray=%b required 0 00000033 0 1", busy_vec_a, rd_data_b[31:0], rd_busy_b[1], stray_a);
        end
    endtask

    task automatic test_x0_stray();
        set_rd(0);
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF;
        claim_en = 1'b1; claim_addr = 0;
        #1;
        checks++;
        if (rd_data_a !== 128'h0 || rd_busy_a !== 4'h0 || claim_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL x0_read: data=%h busy=%h claim_ready=%b required 0 0 1", rd_data_a, rd_busy_a, claim_ready_a);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (stray_a !== 1'b0 || rd_data_b !== 64'h0 || busy_vec_a !== 32'h0) begin
            errors++;
            $display("FAIL x0_write: stray=%b data=%h busy_vec=%h required 0 0 0", stray_a, rd_data_b, busy_vec_a);
        end
        wr_en = 1'b1; wr_addr = 12; wr_data = 32'hC;
        cyc();
        wr_en = 1'b0;
        #1;
        checks++;
        if (stray_a !== 1'b1 || stray_b !== 1'b1) begin
            errors++;
            $display("FAIL stray_set: stray=%b/%b required 1", stray_a, stray_b);
        end
        cyc();
        checks++;
        if (stray_a !== 1'b0) begin
            errors++;
            $display("FAIL stray_pulse: stray=%b required 0", stray_a);
        end
    endtask

    task automatic test_multiport();
        claim_en = 1'b1; claim_addr = 12;
        cyc();
        claim_en = 1'b0;
        set_rd(12);
        #1;
        checks++;
        if (rd_data_a !== {4{32'hC}} || rd_busy_a !== 4'hF) begin
            errors++;
            $display("FAIL multiport_same: data=%h busy=%h required 4x0000000c f", rd_data_a, rd_busy_a);
        end
        rd_addr = {AW'(12), AW'(3), AW'(2), AW'(0)};
        #1;
        checks++;
        if (rd_data_a !== {32'hC, 32'h33, SP_INIT, 32'h0} || rd_busy_a !== 4'b1000) begin
            errors++;
            $display("FAIL multiport_mixed: data=%h busy=%b required 0000000c_00000033_01001000_00000000 1000", rd_data_a, rd_busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_x0_stray();
        test_multiport();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised integer register file for the pipelined core, with configurable read-port count, optional write-to-read bypass, asynchronous reset to a defined architectural state, and a per-register busy scoreboard. Decode claims a destination register at issue. Writeback releases it. Read ports report whether an operand is still pending, so the hazard unit can stall without tracking destinations itself. The block sits between decode/issue and writeback and replaces the single-cycle two-port register file.

## Interface
Parameters:
- DATAW, 32, register width in bits
- NUM_REGS, 32, number of registers; must be a power of two ≥ 2
- ADDRW, $clog2(NUM_REGS), register address width
- NUM_RD_PORTS, 2, number of independent read ports (1–4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only
- SP_INDEX, 2, register loaded with SP_INIT at reset
- SP_INIT, 32'h01001000, stack pointer reset value (top of data memory)

Ports:
- Reset is asynchronous, active-low.
- clock, input, 1, sole clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- rd_addr, input, NUM_RD_PORTS*ADDRW, packed read addresses; port k at [k*ADDRW +: ADDRW]
- rd_data, output, NUM_RD_PORTS*DATAW, packed read data, combinational
- rd_busy, output, NUM_RD_PORTS, 1 = operand on port k still pending
- wr_en, input, 1, writeback valid
- wr_addr, input, ADDRW, writeback destination
- wr_data, input, DATAW, writeback value
- claim_en, input, 1, issue requests ownership of claim_addr
- claim_addr, input, ADDRW, destination being claimed
- claim_ready, output, 1, claim accepted this cycle (combinational)
- flush, input, 1, pipeline flush; clears every busy bit
- busy_vec, output, NUM_REGS, current scoreboard state, bit i = register i busy
- stray_write, output, 1, registered pulse: previous cycle wrote a non-busy register

## Operation
- Storage: regs[0..NUM_REGS-1], busy[0..NUM_REGS-1].
- Register 0 reads as 0. It is never written, never busy, and never flags stray_write.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data and busy[wr_addr] ← 0, unless a claim of the same register is accepted in that same cycle.
- Read port k, combinational:
  - rd_data = 0 if the address is 0.
  - Otherwise, if BYPASS=1 and wr_en and wr_addr==rd_addr_k, rd_data = wr_data.
  - Otherwise rd_data = regs[rd_addr_k].
- rd_busy_k = busy[rd_addr_k], forced to 0 when the address is 0 or a bypass hit occurs. With BYPASS=0 the written register still reads busy until the edge.
- claim_ready = !flush && (claim_addr==0 || !busy[claim_addr] || (wr_en && wr_addr==claim_addr)).
  - The output is valid whether or not claim_en is asserted.
- Accepted claim (claim_en && claim_ready && claim_addr≠0): busy[claim_addr] ← 1 at the edge.
  - Claim wins over a same-cycle write to the same register: the data is written and busy stays 1.
- Rejected claim: no state change. Issue must hold claim_en and claim_addr until claim_ready=1.
- flush=1: all busy bits ← 0 at the edge and the claim is ignored. A write in the same cycle still updates regs.
- stray_write ← wr_en && wr_addr≠0 && !busy[wr_addr], sampled before the update. It is a diagnostic only and never blocks the write.
- Multiple read ports may address the same register or the write address; each resolves independently.

## Timing
- Reset (reset_n=0, asynchronous):
  - all regs = 0 except regs[SP_INDEX] = SP_INIT
  - busy = 0 and stray_write = 0
  - Combinational outputs therefore read: rd_data = reset contents, rd_busy = 0, claim_ready = !flush, busy_vec = 0.
- Reset deassertion: first state change occurs on the first rising edge with reset_n=1. reset_n must deassert synchronously to clock (synchronised upstream).
- Reset mid-operation: pending claims and writes in flight are discarded and the scoreboard returns to all-clear.
- Read latency: 0 cycles (combinational).
  - BYPASS=1: a write becomes visible in the same cycle.
  - BYPASS=0: a write becomes visible the cycle after the edge.
- Claim latency: busy is visible on rd_busy and busy_vec the cycle after acceptance.
- stray_write: 1-cycle registered pulse, asserted the cycle after the offending write.

## Test plan
- Reset: assert reset_n=0 mid-run with busy[5]=1 → regs[2]=32'h01001000, all other regs 0, busy_vec=0, stray_write=0, immediately and without a clock edge.
- Bypass: BYPASS=1, write x7=32'hDEADBEEF with rd_addr port0=7 in the same cycle → rd_data0=DEADBEEF and rd_busy0=0 that cycle. BYPASS=0 → old value and busy shown until the next edge.
- Scoreboard cycle:
  - Claim x9 → next cycle rd_busy=1 on any port reading x9, and a second claim of x9 gives claim_ready=0.
  - Write x9=32'h12 → busy clears and the reread returns 32'h12.
- Simultaneous events:
  - Claim x4 while writing x4 → claim_ready=1, regs[4] updated, busy[4] remains 1.
  - flush with claim x6 and write x3 → busy_vec=0, x6 not busy, x3 written.
- x0 and stray:
  - Write x0=32'hFFFF → reads return 0 and stray_write=0.
  - Write x12 while not busy → stray_write=1 for exactly one cycle.
- Multi-port: NUM_RD_PORTS=4 with all ports reading the same register → identical data and busy on all four ports.
